// File: rtl/pressurize.sv
// Airlock chamber refill controller: vented chamber is refilled on request while doors stay
// sealed; pressurized rises PRESS_CYCLES edges after the accepting edge.
module pressurize #(
    parameter int unsigned PRESS_CYCLES = 6,
    parameter int unsigned CNT_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pressurizeCtrl,
    input  logic evacuated,
    input  logic doorSealed,
    output logic pressurized,
    output logic pressurizing,
    output logic evacClr,
    output logic fault
);

    typedef enum logic [1:0] {
        StPressurized,
        StVented,
        StFilling,
        StFault
    } state_e;

    // Loaded on the accepting edge, so expiry (counter==0) is seen PRESS_CYCLES-1 edges later.
    localparam logic [CNT_W-1:0] Reload = CNT_W'(PRESS_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clr_q, clr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StPressurized;
            cnt_q   <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_d   = 1'b0;
        case (state_q)
            StPressurized: begin
                if (evacuated) state_d = StVented;
            end
            StVented, StFault: begin
                if (pressurizeCtrl && doorSealed) begin
                    state_d = StFilling;
                    cnt_d   = Reload;
                end
            end
            StFilling: begin
                // An unsealed door wins over counter expiry on the same edge.
                if (!doorSealed) begin
                    state_d = StFault;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = StPressurized;
                    clr_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StPressurized;
                cnt_d   = '0;
            end
        endcase
    end

    assign pressurized  = (state_q == StPressurized);
    assign pressurizing = (state_q == StFilling);
    assign fault        = (state_q == StFault);
    assign evacClr      = clr_q;

endmodule

// File: tb/tb_pressurize.sv
// Bench for pressurize: vector table, corner-case sequences and randomized traffic against a
// remaining-edges reference model, on a PRESS_CYCLES=6 and a PRESS_CYCLES=1 instance.
module tb_pressurize;

    logic clk = 1'b0;
    logic rst;
    logic pc, ev, ds;
    logic p6, pz6, ec6, f6;
    logic p1, pz1, ec1, f1;

    int checks = 0;
    int errors = 0;

    pressurize #(.PRESS_CYCLES(6), .CNT_W(4)) u_dut6 (
        .clk(clk), .rst(rst), .pressurizeCtrl(pc), .evacuated(ev), .doorSealed(ds),
        .pressurized(p6), .pressurizing(pz6), .evacClr(ec6), .fault(f6)
    );

    pressurize #(.PRESS_CYCLES(1), .CNT_W(1)) u_dut1 (
        .clk(clk), .rst(rst), .pressurizeCtrl(pc), .evacuated(ev), .doorSealed(ds),
        .pressurized(p1), .pressurizing(pz1), .evacClr(ec1), .fault(f1)
    );

    always #5 clk = ~clk;

    // Model: chamber condition plus number of edges still needed before pressure is reached.
    localparam int MPress = 0, MVent = 1, MFill = 2, MFault = 3;
    int mode[2];
    int left[2];
    bit pulse[2];
    int cycles[2] = '{6, 1};

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i]  = MPress;
            left[i]  = 0;
            pulse[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(input bit e, input bit c, input bit s);
        for (int i = 0; i < 2; i++) begin
            pulse[i] = 1'b0;
            if (mode[i] == MPress) begin
                if (e) mode[i] = MVent;
            end else if (mode[i] == MFill) begin
                if (!s) begin
                    mode[i] = MFault;
                end else begin
                    left[i] = left[i] - 1;
                    if (left[i] == 0) begin
                        mode[i]  = MPress;
                        pulse[i] = 1'b1;
                    end
                end
            end else if (c && s) begin
                mode[i] = MFill;
                left[i] = cycles[i];
            end
        end
    endfunction

    function automatic logic [3:0] model_out(input int i);
        return {mode[i] == MPress, mode[i] == MFill, pulse[i], mode[i] == MFault};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b (pressurized pressurizing evacClr fault) t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_models(input string tag);
        check({tag, "/p6"}, {p6, pz6, ec6, f6}, model_out(0));
        check({tag, "/p1"}, {p1, pz1, ec1, f1}, model_out(1));
    endtask

    // Drive inputs away from the edge, take one edge, sample 1 time unit later.
    task automatic step(input logic e, input logic c, input logic s, input string tag);
        ev = e;
        pc = c;
        ds = s;
        @(posedge clk);
        model_edge(e, c, s);
        #1;
        check_models(tag);
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst6", {p6, pz6, ec6, f6}, 4'b1000);
        rst = 1'b0;
    endtask

    // Reset pulse that starts and ends strictly between two rising edges.
    task automatic pulse_reset();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst6", {p6, pz6, ec6, f6}, 4'b1000);
        check("async_rst1", {p1, pz1, ec1, f1}, 4'b1000);
        #2;
        rst = 1'b0;
    endtask

    task automatic go_vented();
        hard_reset();
        step(1'b1, 1'b0, 1'b1, "vent");
    endtask

    typedef struct packed {
        logic       e;
        logic       c;
        logic       s;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[18];

    initial begin
        vecs[0]  = {3'b100, 4'b0000}; // evacuated -> vented
        vecs[1]  = {3'b011, 4'b0100}; // accept, edge N
        vecs[2]  = {3'b001, 4'b0100};
        vecs[3]  = {3'b101, 4'b0100}; // evacuated ignored mid-fill
        vecs[4]  = {3'b011, 4'b0100}; // request ignored mid-fill
        vecs[5]  = {3'b001, 4'b0100};
        vecs[6]  = {3'b001, 4'b0100}; // edge N+5
        vecs[7]  = {3'b001, 4'b1010}; // edge N+6: pressurized with evacClr
        vecs[8]  = {3'b010, 4'b1000}; // pulse gone, inputs ignored
        vecs[9]  = {3'b100, 4'b0000};
        vecs[10] = {3'b010, 4'b0000}; // request with door open ignored
        vecs[11] = {3'b011, 4'b0100};
        vecs[12] = {3'b001, 4'b0100};
        vecs[13] = {3'b001, 4'b0100};
        vecs[14] = {3'b000, 4'b0001}; // door unsealed at N+3
        vecs[15] = {3'b010, 4'b0001};
        vecs[16] = {3'b001, 4'b0001};
        vecs[17] = {3'b011, 4'b0100}; // restart from fault

        rst = 1'b1;
        ev  = 1'b0;
        pc  = 1'b0;
        ds  = 1'b0;
        model_reset();
        #1;
        check("reset6", {p6, pz6, ec6, f6}, 4'b1000);
        check("reset1", {p1, pz1, ec1, f1}, 4'b1000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].e, vecs[i].c, vecs[i].s, "vec");
            check($sformatf("vec%0d", i), {p6, pz6, ec6, f6}, vecs[i].exp);
        end

        // Request with the door open never starts a fill.
        go_vented();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, "open");
            check("open_door", {p6, pz6, ec6, f6}, 4'b0000);
        end

        // Door opens on the very edge the fill would complete.
        go_vented();
        step(1'b0, 1'b1, 1'b1, "exp");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, "exp");
            check("exp_fill", {p6, pz6, ec6, f6}, 4'b0100);
        end
        step(1'b0, 1'b0, 1'b0, "exp");
        check("exp_fault", {p6, pz6, ec6, f6}, 4'b0001);
        step(1'b0, 1'b0, 1'b0, "exp");
        check("exp_nopulse", {p6, pz6, ec6, f6}, 4'b0001);

        // Reset mid-fill abandons it with no evacClr pulse.
        go_vented();
        step(1'b0, 1'b1, 1'b1, "mid");
        step(1'b0, 1'b0, 1'b1, "mid");
        step(1'b0, 1'b0, 1'b1, "mid");
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, "mid");
            check("mid_rst_hold", {p6, pz6, ec6, f6}, 4'b1000);
        end
        step(1'b1, 1'b0, 1'b1, "mid");
        check("mid_rst_vent", {p6, pz6, ec6, f6}, 4'b0000);

        // Single-cycle instance: pressure on the edge right after acceptance.
        go_vented();
        step(1'b0, 1'b1, 1'b1, "one");
        check("one_accept", {p1, pz1, ec1, f1}, 4'b0100);
        step(1'b0, 1'b0, 1'b1, "one");
        check("one_done", {p1, pz1, ec1, f1}, 4'b1010);
        step(1'b0, 1'b0, 1'b1, "one");
        check("one_after", {p1, pz1, ec1, f1}, 4'b1000);

        hard_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) != 0), "rand");
            if ($urandom_range(0, 49) == 0) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
